axil_regbank: RTL

Parametrised AXI4-Lite slave register bank for the DRAM controller control path. It uses full valid/ready handshakes on all five channels and accepts AW and W independently. It applies byte strobes, returns OKAY/SLVERR responses, and splits the register space into RW control registers (exported to the datapath) and RO status registers (sampled from hardware).

---
 rtl/axil_pkg.sv | 23 ++
 rtl/axil_strb_merge.sv | 25 ++
 rtl/axil_regbank.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared constants and state encodings for the AXI4-Lite register bank.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

  // IRQ registers sit just below the read-only block, counted down from it.
  localparam int unsigned IRQ_STATUS_OFS = 1;
  localparam int unsigned IRQ_ENABLE_OFS = 2;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-lane merge of old/new register data under a strobe mask.
// In W1C mode a strobed byte clears the bits set in the new data.
module axil_strb_merge
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_new,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  input  logic                    i_w1c,
  output logic [DATA_WIDTH-1:0]   o_data
);

  always_comb begin
    o_data = i_old;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      if (i_strb[b]) begin
        o_data[b*8 +: 8] = i_w1c ? (i_old[b*8 +: 8] & ~i_new[b*8 +: 8])
                                 : i_new[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank: RW control registers plus RO status registers.
// Optional IRQ status/enable pair enabled by defining AXIL_IRQ_EN.
module axil_regbank
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned NUM_RO     = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       awvalid,
  output logic                                       awready,
  input  logic [ADDR_WIDTH-1:0]                      awaddr,
  input  logic                                       wvalid,
  output logic                                       wready,
  input  logic [DATA_WIDTH-1:0]                      wdata,
  input  logic [DATA_WIDTH/8-1:0]                    wstrb,
  output logic                                       bvalid,
  input  logic                                       bready,
  output logic [1:0]                                 bresp,
  input  logic                                       arvalid,
  output logic                                       arready,
  input  logic [ADDR_WIDTH-1:0]                      araddr,
  output logic                                       rvalid,
  input  logic                                       rready,
  output logic [DATA_WIDTH-1:0]                      rdata,
  output logic [1:0]                                 rresp,
  output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0]    ctrl_regs,
  output logic [NUM_REGS-NUM_RO-1:0]                 ctrl_wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in
`ifdef AXIL_IRQ_EN
  ,
  input  logic [DATA_WIDTH-1:0]                      irq_src,
  output logic                                       irq
`endif
);

  localparam int unsigned SW  = DATA_WIDTH / 8;
  localparam int unsigned SH  = $clog2(SW);
  localparam int unsigned IW  = $clog2(NUM_REGS);
  localparam int unsigned NRW = NUM_REGS - NUM_RO;
`ifdef AXIL_IRQ_EN
  localparam int unsigned IRQ_STAT = NRW - IRQ_STATUS_OFS;
  localparam int unsigned IRQ_EN   = NRW - IRQ_ENABLE_OFS;
`endif

  wstate_t                    r_wstate;
  rstate_t                    r_rstate;
  logic                       r_awready;
  logic                       r_wready;
  logic                       r_arready;
  logic                       r_bvalid;
  logic [1:0]                 r_bresp;
  logic                       r_rvalid;
  logic [1:0]                 r_rresp;
  logic [DATA_WIDTH-1:0]      r_rdata;
  logic [ADDR_WIDTH-1:SH]     r_awaddr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [SW-1:0]              r_wstrb;
  logic [DATA_WIDTH-1:0]      r_regs [NRW];
  logic [NRW-1:0]             r_pulse;

  logic                       w_aw_hs;
  logic                       w_w_hs;
  logic                       w_ar_hs;
  logic                       w_commit;
  logic [ADDR_WIDTH-1:SH]     w_caddr;
  logic [DATA_WIDTH-1:0]      w_cdata;
  logic [SW-1:0]              w_cstrb;
  logic [IW-1:0]              w_widx;
  logic                       w_woor;
  logic                       w_wok;
  logic                       w_w1c;
  logic [DATA_WIDTH-1:0]      w_old;
  logic [DATA_WIDTH-1:0]      w_merged;
  logic [DATA_WIDTH-1:0]      w_regs_nx [NRW];
  logic [NRW-1:0]             w_pulse_nx;
  logic [IW-1:0]              w_ridx;
  logic                       w_roor;
  logic [DATA_WIDTH-1:0]      w_rsel;
  logic                       w_unused_ok;

  assign w_unused_ok = &{1'b0, awaddr[SH-1:0], araddr[SH-1:0]};

  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs  = wvalid & r_wready;
  assign w_ar_hs = arvalid & r_arready;

  // Each half is either held from an earlier handshake or firing now.
  assign w_commit = (w_aw_hs || (r_wstate == W_HAVE_AW)) &&
                    (w_w_hs  || (r_wstate == W_HAVE_W));

  assign w_caddr = w_aw_hs ? awaddr[ADDR_WIDTH-1:SH] : r_awaddr;
  assign w_cdata = w_w_hs ? wdata : r_wdata;
  assign w_cstrb = w_w_hs ? wstrb : r_wstrb;
  assign w_widx  = w_caddr[SH +: IW];
  assign w_woor  = |w_caddr[ADDR_WIDTH-1:SH+IW];
  assign w_wok   = !w_woor && ({1'b0, w_widx} < (IW+1)'(NRW));

`ifdef AXIL_IRQ_EN
  assign w_w1c = (w_widx == IW'(IRQ_STAT));
`else
  assign w_w1c = 1'b0;
`endif

  always_comb begin
    w_old = '0;
    for (int unsigned i = 0; i < NRW; i++) begin
      if (w_widx == IW'(i)) w_old = r_regs[i];
    end
  end

  axil_strb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .i_old  (w_old),
    .i_new  (w_cdata),
    .i_strb (w_cstrb),
    .i_w1c  (w_w1c),
    .o_data (w_merged)
  );

  always_comb begin
    w_pulse_nx = '0;
    for (int unsigned i = 0; i < NRW; i++) begin
      w_regs_nx[i] = r_regs[i];
      if (w_commit && w_wok && (w_widx == IW'(i))) begin
        w_regs_nx[i]  = w_merged;
        w_pulse_nx[i] = 1'b1;
      end
    end
`ifdef AXIL_IRQ_EN
    // Sticky set is applied after the W1C merge so a coincident set wins.
    w_regs_nx[IRQ_STAT] = w_regs_nx[IRQ_STAT] | irq_src;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_pulse   <= '0;
      for (int unsigned i = 0; i < NRW; i++) r_regs[i] <= '0;
    end else begin
      r_regs  <= w_regs_nx;
      r_pulse <= w_pulse_nx;
      if (w_commit) begin
        r_wstate  <= W_RESP;
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        case (r_wstate)
          W_IDLE: begin
            if (w_aw_hs) begin
              r_awaddr  <= awaddr[ADDR_WIDTH-1:SH];
              r_awready <= 1'b0;
              r_wstate  <= W_HAVE_AW;
            end else if (w_w_hs) begin
              r_wdata  <= wdata;
              r_wstrb  <= wstrb;
              r_wready <= 1'b0;
              r_wstate <= W_HAVE_W;
            end
          end
          W_HAVE_AW, W_HAVE_W: ;
          W_RESP: begin
            if (bready) begin
              r_bvalid  <= 1'b0;
              r_awready <= 1'b1;
              r_wready  <= 1'b1;
              r_wstate  <= W_IDLE;
            end
          end
          default: r_wstate <= W_IDLE;
        endcase
      end
    end
  end

  assign w_ridx = araddr[SH +: IW];
  assign w_roor = |araddr[ADDR_WIDTH-1:SH+IW];

  always_comb begin
    w_rsel = '0;
    if (!w_roor) begin
      for (int unsigned i = 0; i < NRW; i++) begin
        if (w_ridx == IW'(i)) w_rsel = r_regs[i];
      end
      for (int unsigned j = 0; j < NUM_RO; j++) begin
        if (w_ridx == IW'(NRW + j)) w_rsel = status_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata   <= w_rsel;
            r_rresp   <= w_roor ? RESP_SLVERR : RESP_OKAY;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

`ifdef AXIL_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= |(r_regs[IRQ_STAT] & r_regs[IRQ_EN]);
  end

  assign irq = r_irq;
`endif

  for (genvar g = 0; g < NRW; g++) begin : g_flat
    assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign awready       = r_awready;
  assign wready        = r_wready;
  assign arready       = r_arready;
  assign bvalid        = r_bvalid;
  assign bresp         = r_bresp;
  assign rvalid        = r_rvalid;
  assign rresp         = r_rresp;
  assign rdata         = r_rdata;
  assign ctrl_wr_pulse = r_pulse;

endmodule
